small_comb_fifo: RTL and testbench
==================================

SMALL_COMB_FIFO -- requirements
Module: small_comb_fifo

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DW, default 8, SHALL set the data word width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the number of storage entries and SHALL be a power of two, at least 2.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port wr_valid, input, 1 bit, SHALL flag that wr_data holds a word from the upstream combinational stage.
REQ-007 Port wr_data, input, DW bits, SHALL carry the upstream result word (8-bit d_out of the combinational stage).
REQ-008 Port wr_ready, output, 1 bit, SHALL be high when a write can be accepted.
REQ-009 Port rd_valid, output, 1 bit, SHALL be high when rd_data holds the oldest stored word.
REQ-010 Port rd_data, output, DW bits, SHALL carry the oldest stored word.
REQ-011 Port rd_ready, input, 1 bit, SHALL flag that the consumer takes rd_data this cycle.
REQ-012 Port level, output, log2(DEPTH)+1 bits, SHALL give the current occupancy, 0..DEPTH.
REQ-013 Port overflow, output, 1 bit, SHALL be a sticky flag for a refused write attempt.

Function
REQ-014 Write accept SHALL occur on a rising edge where wr_valid=1 and wr_ready=1; the word goes to mem[wr_ptr] and wr_ptr increments.
REQ-015 Read accept SHALL occur on a rising edge where rd_valid=1 and rd_ready=1; rd_ptr increments.
REQ-016 wr_ready SHALL equal (level != DEPTH), combinational from registered state only, with no path from wr_valid or rd_ready.
REQ-017 rd_valid SHALL equal (level != 0); rd_data SHALL equal mem[rd_ptr] combinationally.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N SHALL be visible with rd_valid=1 immediately after edge N when the FIFO was empty.
REQ-019 Word order SHALL be strict FIFO; no word SHALL be dropped, duplicated or altered.
REQ-020 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-021 level SHALL update +1 on write only, -1 on read only, and stay unchanged on simultaneous write and read.
REQ-022 When full with rd_ready=1, the read SHALL complete, the write SHALL be refused (wr_ready=0 that cycle), and level SHALL become DEPTH-1.
REQ-023 When empty, no read SHALL occur; a simultaneous write SHALL be accepted normally.
REQ-024 overflow SHALL set on any edge with wr_valid=1 and wr_ready=0, and SHALL clear only on reset.
REQ-025 When rd_valid=0, rd_data SHALL be don't-care; the bench SHALL check it only when rd_valid=1.

Reset
REQ-026 While rst=1 at a rising edge: wr_ptr=0, rd_ptr=0, level=0, overflow=0, giving wr_ready=1 and rd_valid=0 after that edge.
REQ-027 Reset SHALL take priority over simultaneous read/write; in-flight words SHALL be discarded.
REQ-028 Storage contents SHALL NOT be reset.

Structure
REQ-029 Package small_comb_pkg SHALL hold the DW and DEPTH defaults and the derived AW = log2(DEPTH) constant.
REQ-030 The storage array SHALL be the sub-module small_comb_fifo_mem (DEPTH x DW, one synchronous write port, one asynchronous read port); pointers, level and flags SHALL stay in small_comb_fifo.

Verification
REQ-031 Reset, then write 0x5A with rd_ready=0 -> after one edge rd_valid=1, rd_data=0x5A, level=1.
REQ-032 Write 0x01,0x02,0x03,0x04 with rd_ready=0 -> level=4, wr_ready=0; a fifth write attempt sets overflow=1; draining gives 0x01..0x04 in order.
REQ-033 Full FIFO, wr_valid=1 (0xEE) and rd_ready=1 on the same edge -> 0x01 read, 0xEE refused, level=3, overflow=1.
REQ-034 Level 2, continuous write plus read for 10 cycles -> level stays 2, pointers wrap, output order is exact.
REQ-035 Assert rst mid-stream at level 3 -> after the edge level=0, rd_valid=0, overflow=0, wr_ready=1.
REQ-036 Random wr_valid/rd_ready traffic for 1000 cycles against a queue model -> zero data mismatches, and level always in 0..4.

Source files
------------

// File: rtl/small_comb_pkg.sv
// Shared sizing defaults for the small result FIFO that sits behind the
// combinational stage.
package small_comb_pkg;
  localparam int SC_DW    = 8;
  localparam int SC_DEPTH = 4;
  localparam int SC_AW    = $clog2(SC_DEPTH);
endpackage

// File: rtl/small_comb_fifo_mem.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module small_comb_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DEPTH-1:0][DW-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/small_comb_fifo.sv
// Small synchronous FIFO buffering upstream combinational results.
// Handshake flags depend only on registered occupancy, never on wr_valid/rd_ready.
module small_comb_fifo
  import small_comb_pkg::*;
#(
  parameter int DW    = SC_DW,
  parameter int DEPTH = SC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [DW-1:0]            wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_acc, rd_acc;

  assign wr_ready = (level != FULL_LVL);
  assign rd_valid = (level != '0);
  assign wr_acc   = wr_valid & wr_ready;
  assign rd_acc   = rd_valid & rd_ready;

  small_comb_fifo_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_valid && !wr_ready) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_small_comb_fifo.sv
// Directed and random checks of small_comb_fifo against hand-computed values
// and a queue model.
module tb_small_comb_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, wr_valid, rd_ready;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid, overflow;
  logic [DW-1:0] rd_data;
  logic [2:0]    level;

  int checks = 0;
  int passed = 0;

  small_comb_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_valid = 1'b1; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    int         s;
    logic       ovf_m;
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_level", level, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_overflow", overflow, 0);

    // single word, one-cycle latency
    write_word(8'h5A);
    check("w1_rd_valid", rd_valid, 1);
    check("w1_rd_data", rd_data, 8'h5A);
    check("w1_level", level, 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("w1_drained", level, 0);
    check("w1_empty", rd_valid, 0);

    // fill, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) write_word(8'(i));
    check("full_level", level, 4);
    check("full_wr_ready", wr_ready, 0);
    check("full_no_ovf", overflow, 0);
    write_word(8'h55);
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 4);
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", rd_data, 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    check("drain_level", level, 0);
    check("ovf_sticky", overflow, 1);

    // full with simultaneous write and read: read wins, write refused
    do_reset();
    check("rst2_ovf", overflow, 0);
    for (int i = 1; i <= 4; i++) write_word(8'(i));
    wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
    check("fr_wr_ready", wr_ready, 0);
    check("fr_rd_data", rd_data, 8'h01);
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("fr_level", level, 3);
    check("fr_ovf", overflow, 1);
    rd_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      check("fr_drain", rd_data, 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    check("fr_empty", level, 0);

    // steady-state streaming at level 2, pointers wrap several times
    write_word(8'h10);
    write_word(8'h11);
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'h12 + i);
      check("str_data", rd_data, 32'(8'h10 + i));
      tick();
      check("str_level", level, 2);
    end
    wr_valid = 1'b0;
    check("str_tail0", rd_data, 8'h1A);
    tick();
    check("str_tail1", rd_data, 8'h1B);
    tick();
    rd_ready = 1'b0;
    check("str_empty", level, 0);

    // reset mid-stream with traffic on the same edge
    for (int i = 0; i < 3; i++) write_word(8'(8'hA0 + i));
    check("mr_level3", level, 3);
    check("mr_ovf_before", overflow, 1);
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
    tick();
    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    check("mr_level", level, 0);
    check("mr_rd_valid", rd_valid, 0);
    check("mr_ovf", overflow, 0);
    check("mr_wr_ready", wr_ready, 1);

    // random traffic against a queue model
    ovf_m = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      wr_valid = ($urandom_range(0, 9) < 6);
      rd_ready = ($urandom_range(0, 9) < 5);
      d = 8'($urandom);
      wr_data = d;
      s = q.size();
      check("rnd_wr_ready", wr_ready, 32'(s != DEPTH));
      check("rnd_rd_valid", rd_valid, 32'(s != 0));
      if (rd_valid && s != 0) check("rnd_data", rd_data, q[0]);
      tick();
      if (rd_ready && s != 0) void'(q.pop_front());
      if (wr_valid && s != DEPTH) q.push_back(d);
      if (wr_valid && s == DEPTH) ovf_m = 1'b1;
      check("rnd_level", level, q.size());
      check("rnd_ovf", overflow, ovf_m);
    end
    wr_valid = 1'b0; rd_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
